// File: rtl/led_bank_arbiter.sv
// Three-requester LED bank arbiter with time-sliced ownership and a one-cycle gap between owners.
// Define LED_ARB_RR_EN for round-robin winner selection; fixed priority (index 0 highest) otherwise.
module led_bank_arbiter #(
  parameter int unsigned SLICE        = 75_000_000,
  parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] pat0,
  input  logic [15:0] pat1,
  input  logic [15:0] pat2,
  output logic [2:0]  gnt,
  output logic [15:0] led,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_e;

  localparam logic [31:0] LAST_CNT = 32'(SLICE - 1);

  state_e      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [15:0] led_q, led_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  owner_q, owner_d;

  logic [2:0]  owner_oh;
  logic [2:0]  others;
  logic [2:0]  cand;
  logic [1:0]  winner;
  logic [15:0] pat_sel;

  assign owner_oh = 3'b001 << owner_q;
  assign others   = req & ~owner_oh;

  // Outside SWITCH the previous owner competes normally; inside it yields only to someone else.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cand = req;
    if (state_q == SWITCH && others != 3'b000) cand = others;
  end

`ifdef LED_ARB_RR_EN
  always_comb begin
    int idx;
    winner = owner_q;
    // Scan from furthest to nearest after the last owner so the nearest requester wins.
    for (int k = 3; k >= 1; k--) begin
      idx = int'(owner_q) + k;
      if (idx >= 3) idx = idx - 3;
      if (cand[idx]) winner = idx[1:0];
    end
  end
`else
  always_comb begin
    winner = 2'd2;
    if (cand[1]) winner = 2'd1;
    if (cand[0]) winner = 2'd0;
  end
`endif

  always_comb begin
    pat_sel = pat2;
    case (owner_q)
      2'd0:    pat_sel = pat0;
      2'd1:    pat_sel = pat1;
      default: pat_sel = pat2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          state_d = OWN;
          gnt_d   = 3'b001 << winner;
          owner_d = winner;
          cnt_d   = '0;
        end
      end
      OWN: begin
        led_d = pat_sel;
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
          led_d   = IDLE_PATTERN;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          if (others != 3'b000) begin
            state_d = SWITCH;
            gnt_d   = 3'b000;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      SWITCH: begin
        if (req != 3'b000) begin
          state_d = OWN;
          gnt_d   = 3'b001 << winner;
          owner_d = winner;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          led_d   = IDLE_PATTERN;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        led_d   = IDLE_PATTERN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      led_q   <= IDLE_PATTERN;
      cnt_q   <= '0;
      owner_q <= 2'd2;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  assign gnt  = gnt_q;
  assign led  = led_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed-vector bench for led_bank_arbiter at SLICE=8; expectations follow LED_ARB_RR_EN if defined.
module tb_led_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [15:0] pat0, pat1, pat2;
  logic [2:0]  gnt;
  logic [15:0] led;
  logic        busy;

  int n_vec;
  int n_err;

  led_bank_arbiter #(.SLICE(8), .IDLE_PATTERN(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .pat0(pat0), .pat1(pat1), .pat2(pat2),
    .gnt(gnt), .led(led), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 3'b000;
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [15:0] pat_of(input int o);
    case (o)
      0:       return pat0;
      1:       return pat1;
      default: return pat2;
    endcase
  endfunction

  // Called one cycle after the edge that granted owner o: expects 8 owned cycles, then the SWITCH gap.
  task automatic own_slot(input int o, input string tag);
    for (int c = 0; c < 8; c++) begin
      check({tag, " gnt"}, 32'(gnt), 32'(3'b001 << o));
      if (c > 0) check({tag, " led"}, 32'(led), 32'(pat_of(o)));
      tick();
    end
    check({tag, " gap gnt"}, 32'(gnt), 32'd0);
    check({tag, " gap busy"}, 32'(busy), 32'd1);
    check({tag, " gap led"}, 32'(led), 32'(pat_of(o)));
  endtask

  int rot[4];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 3'b000;
    pat0  = 16'h1111;
    pat1  = 16'hA5A5;
    pat2  = 16'h3333;
    #2;
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset led", 32'(led), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    check("idle after reset busy", 32'(busy), 32'd0);

    // Single requester 1: grant after one edge, pattern one edge later, then release.
    req = 3'b010;
    tick();
    check("r1 gnt", 32'(gnt), 32'b010);
    check("r1 busy", 32'(busy), 32'd1);
    check("r1 led not yet", 32'(led), 32'h0000);
    tick();
    check("r1 led", 32'(led), 32'hA5A5);
    check("r1 busy2", 32'(busy), 32'd1);
    req = 3'b000;
    tick();
    check("r1 drop gnt", 32'(gnt), 32'd0);
    check("r1 drop led", 32'(led), 32'h0000);
    check("r1 drop busy", 32'(busy), 32'd0);

    // Two requesters: 0 first, one-cycle gap, then 1 (both modes).
    pat1 = 16'h2222;
    do_reset();
    req = 3'b011;
    tick();
    own_slot(0, "pair o0");
    tick();
    check("pair o1 gnt", 32'(gnt), 32'b010);

    // Lone owner keeps the grant past the slice; a late competitor forces a switch.
    do_reset();
    req = 3'b001;
    tick();
    for (int c = 0; c < 12; c++) begin
      check("hold gnt", 32'(gnt), 32'b001);
      tick();
    end
    req = 3'b011;
    tick();
    check("late sw gnt", 32'(gnt), 32'd0);
    tick();
    check("late sw new gnt", 32'(gnt), 32'b010);
    // Previous owner is the only requester in SWITCH: it is granted again.
    own_slot(1, "excl o1");
    req = 3'b010;
    tick();
    check("regrant gnt", 32'(gnt), 32'b010);
    req = 3'b000;
    tick();
    check("regrant drop busy", 32'(busy), 32'd0);

    // All three requesting, rotation order depends on the selection mode.
`ifdef LED_ARB_RR_EN
    rot = '{0, 1, 2, 0};
`else
    rot = '{0, 1, 0, 1};
`endif
    do_reset();
    req = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      own_slot(rot[k], $sformatf("rot%0d", k));
      if (k < 3) tick();
    end
    req = 3'b000;
    tick();
    check("switch to idle gnt", 32'(gnt), 32'd0);
    check("switch to idle busy", 32'(busy), 32'd0);
    check("switch to idle led", 32'(led), 32'h0000);

    // Owner 0 drops at counter=3.
    pat0 = 16'h5A5A;
    do_reset();
    req = 3'b001;
    tick();
    tick();
    tick();
    tick();
    check("early led", 32'(led), 32'h5A5A);
    req = 3'b000;
    tick();
    check("early drop gnt", 32'(gnt), 32'd0);
    check("early drop busy", 32'(busy), 32'd0);
    check("early drop led", 32'(led), 32'h0000);

    // Asynchronous reset mid-OWN, then the grant returns after one edge.
    pat0 = 16'hFFFF;
    do_reset();
    req = 3'b001;
    tick();
    tick();
    check("pre-rst led", 32'(led), 32'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst led", 32'(led), 32'h0000);
    check("async rst gnt", 32'(gnt), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("post-rst gnt", 32'(gnt), 32'b001);
    check("post-rst busy", 32'(busy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_bank_arbiter.md
LED_BANK_ARBITER -- requirements
Module: led_bank_arbiter

Interface
REQ-001 Parameter SLICE, default 75_000_000; time-slice length in clk cycles (1 s at 75 MHz); legal range 2..2^32-1.
REQ-002 Parameter IDLE_PATTERN, default 16'h0000; value driven on led when no requester owns the bank.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  3  per-requester request level; bit i belongs to requester i.
REQ-006 pat0, pat1, pat2  input  16 each  LED pattern offered by requester 0/1/2; sampled only while that requester is granted.
REQ-007 gnt  output  3  registered one-hot grant, or all-zero.
REQ-008 led  output  16  registered LED bank drive.
REQ-009 busy  output  1  high whenever state is not IDLE.

Function
REQ-010 The FSM SHALL have three states: IDLE, OWN and SWITCH; the encoding is free.
REQ-011 In IDLE, with req != 0 at edge t, the arbiter SHALL select a winner per REQ-019/REQ-020, enter OWN, and assert gnt[winner] after edge t.
REQ-012 In IDLE, gnt SHALL be 0 and led SHALL be IDLE_PATTERN, loaded on the edge that enters IDLE.
REQ-013 In OWN, on every edge led SHALL load pat[owner]: 1-cycle latency from pattern input to led, and the first update occurs on the edge after gnt rises.
REQ-014 A 32-bit slice counter SHALL clear on entry to OWN, increment each OWN cycle, and saturate at SLICE-1.
REQ-015 In OWN, if req[owner]=0, the arbiter SHALL drop gnt on the next edge and enter IDLE; this takes precedence over slice expiry.
REQ-016 In OWN, if counter=SLICE-1, req[owner]=1, and any other req bit is 1, the arbiter SHALL enter SWITCH.
REQ-017 In OWN with no other requester pending, the owner SHALL keep the grant indefinitely, with the counter held at SLICE-1.
REQ-018 SWITCH SHALL last exactly one cycle: gnt=0, led holds its last value, and the winner is chosen from req sampled in SWITCH, excluding the previous owner only if another bit is set. The arbiter then enters OWN with the new gnt, or IDLE if req=0.
REQ-019 The winner SHALL be selected in fixed priority, with index 0 highest, unless the macro in REQ-025 is defined.
REQ-020 The arbiter SHALL keep a 2-bit last-owner register, updated on every grant and reset to 2.
REQ-021 gnt SHALL never have more than one bit set, and SHALL be 0 for at least one cycle between different owners.
REQ-022 A req pulse shorter than one cycle is not detected; req is level-sampled only.

Reset
REQ-023 When rst_n=0, the block SHALL immediately (asynchronously) set state=IDLE, gnt=0, led=IDLE_PATTERN, busy=0, counter=0 and last-owner=2; this applies mid-OWN and mid-SWITCH alike.
REQ-024 After rst_n rises, the first arbitration SHALL happen on the first clk edge with req != 0.

Configuration
REQ-025 Macro LED_ARB_RR_EN: when defined, winner selection SHALL be round-robin, i.e. the first requesting index after last-owner, wrapping 2->0. When undefined, fixed priority per REQ-019 applies, and last-owner is used only for the exclusion in REQ-018.

Verification (SLICE=8, IDLE_PATTERN=16'h0000)
REQ-026 Set req=3'b010 and pat1=16'hA5A5 from IDLE: gnt=3'b010 one cycle later, led=16'hA5A5 the following cycle, and busy=1 throughout.
REQ-027 Set req=3'b011 from IDLE (fixed priority): gnt=3'b001 for 8 cycles, then 1 cycle gnt=0, then gnt=3'b010. The same holds with LED_ARB_RR_EN, because last-owner=2 after reset gives requester 0 first.
REQ-028 Set req=3'b111, all held, with LED_ARB_RR_EN: grants SHALL cycle 0->1->2->0, each lasting 8 cycles plus a 1-cycle gap. Without the macro: 0->1->0->1.
REQ-029 Owner 0 drops req at counter=3: gnt=0 on the next edge, state IDLE, and led=16'h0000 on that edge.
REQ-030 Assert rst_n=0 asynchronously mid-OWN with led=16'hFFFF: led=0, gnt=0 and busy=0 before the next clk edge. After release with req held, the grant returns after one edge.
